// File: rtl/grid_renderer_pkg.sv
// Shared encodings and palette for the battleship board: status codes
// written by the board-state writer and the colours the renderer draws.
package grid_renderer_pkg;

    localparam int unsigned GRID_N = 10;

    typedef enum logic [1:0] {
        ST_WATER = 2'b00,
        ST_MISS  = 2'b01,
        ST_HIT   = 2'b10,
        ST_SUNK  = 2'b11
    } cell_status_t;

    localparam logic [11:0] COL_BLANK  = 12'h000;
    localparam logic [11:0] COL_CURSOR = 12'hFF0;
    localparam logic [11:0] COL_GRID   = 12'hFFF;
    localparam logic [11:0] COL_WATER  = 12'h00F;
    localparam logic [11:0] COL_MISS   = 12'h888;
    localparam logic [11:0] COL_HIT    = 12'h000;
    localparam logic [11:0] COL_SUNK   = 12'hF00;
    localparam logic [11:0] COL_BAR    = 12'h0F0;
    localparam logic [11:0] COL_BG     = 12'h222;

    // Map a 2-bit cell status to its fill colour.
    function automatic logic [11:0] status_colour(input logic [1:0] st);
        logic [11:0] c;
        case (cell_status_t'(st))
            ST_WATER: c = COL_WATER;
            ST_MISS:  c = COL_MISS;
            ST_HIT:   c = COL_HIT;
            default:  c = COL_SUNK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/grid_renderer_cell_tracker.sv
// Cell-position tracker: follows a scan counter through GRID_N cells of
// CELL pixels each, starting at START, yielding cell index and offset
// without any division.
module cell_tracker
    import grid_renderer_pkg::*;
#(
    parameter logic [9:0] START = 10'd0,
    parameter logic [5:0] CELL  = 6'd40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [9:0] pos,
    output logic [3:0] idx,
    output logic [5:0] off,
    output logic       active
);

    localparam logic [3:0] LAST_IDX = 4'(GRID_N - 1);

    logic start_match;

    assign start_match = (pos == START);

    // Restart on the start coordinate, otherwise step offset/index until the last cell ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx    <= '0;
            off    <= '0;
            active <= 1'b0;
        end else if (en) begin
            if (start_match) begin
                idx    <= '0;
                off    <= '0;
                active <= 1'b1;
            end else if (active) begin
                if (off == CELL - 6'd1) begin
                    off <= '0;
                    if (idx == LAST_IDX) begin
                        active <= 1'b0;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end else begin
                    off <= off + 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/grid_renderer.sv
// Pixel colour pipeline for the 10x10 battleship grid and turns bar.
// Stage 1 tracks cell position and registers timing; stage 2 picks colour.
module grid_renderer
    import grid_renderer_pkg::*;
#(
    parameter logic [9:0] GRID_X0  = 10'd144,
    parameter logic [9:0] GRID_Y0  = 10'd35,
    parameter logic [5:0] CELL     = 6'd40,
    parameter logic [9:0] BAR_Y0   = 10'd450,
    parameter logic [9:0] BAR_H    = 10'd10,
    parameter logic [5:0] BAR_STEP = 6'd16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [9:0]   hc,
    input  logic [9:0]   vc,
    input  logic         bright,
    input  logic         hsync_in,
    input  logic         vsync_in,
    input  logic [199:0] cell_status_flat,
    input  logic [4:0]   turns_left,
    input  logic [3:0]   sprite_row,
    input  logic [3:0]   sprite_col,
    output logic [11:0]  rgb,
    output logic         hsync_out,
    output logic         vsync_out
);

    logic [3:0]  col, row;
    logic [5:0]  px, py;
    logic        in_x, in_y;
    logic        line_start;

    logic        bright_q, hsync_q, vsync_q;
    logic [9:0]  hc_q, vc_q;

    logic [6:0]  cell_idx;
    logic [1:0]  cell_st;
    logic        in_grid, on_cursor, on_border, on_bar;
    logic [9:0]  bar_len;
    logic [11:0] rgb_next;

    assign line_start = (hc == 10'd0);

    cell_tracker #(.START(GRID_X0), .CELL(CELL)) u_x_tracker (
        .clk    (clk),
        .reset  (reset),
        .en     (1'b1),
        .pos    (hc),
        .idx    (col),
        .off    (px),
        .active (in_x)
    );

    // The row tracker advances once per line, on the hc==0 cycle.
    cell_tracker #(.START(GRID_Y0), .CELL(CELL)) u_y_tracker (
        .clk    (clk),
        .reset  (reset),
        .en     (line_start),
        .pos    (vc),
        .idx    (row),
        .off    (py),
        .active (in_y)
    );

    // Stage 1: register timing signals alongside the tracker outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bright_q <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            hc_q     <= '0;
            vc_q     <= '0;
        end else begin
            bright_q <= bright;
            hsync_q  <= hsync_in;
            vsync_q  <= vsync_in;
            hc_q     <= hc;
            vc_q     <= vc;
        end
    end

    // Stage 2 colour decision, first matching layer wins.
    always_comb begin
        cell_idx  = {row, 3'b000} + {2'b00, row, 1'b0} + {3'b000, col};
        cell_st   = cell_status_flat[{cell_idx, 1'b0} +: 2];
        in_grid   = in_x && in_y;
        on_cursor = (row == sprite_row) && (col == sprite_col);
        on_border = (px < 6'd2) || (px >= CELL - 6'd2) ||
                    (py < 6'd2) || (py >= CELL - 6'd2);
        bar_len   = {5'b00000, turns_left} * {4'b0000, BAR_STEP};
        on_bar    = (vc_q >= BAR_Y0) && (vc_q < BAR_Y0 + BAR_H) &&
                    (hc_q >= GRID_X0) && (hc_q < GRID_X0 + bar_len);
        rgb_next  = COL_BG;
        if (!bright_q) begin
            rgb_next = COL_BLANK;
        end else if (in_grid && on_cursor && on_border) begin
            rgb_next = COL_CURSOR;
        end else if (in_grid && ((px == 6'd0) || (py == 6'd0))) begin
            rgb_next = COL_GRID;
        end else if (in_grid) begin
            rgb_next = status_colour(cell_st);
        end else if (on_bar) begin
            rgb_next = COL_BAR;
        end
    end

    // Stage 2 output register; syncs idle high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb       <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            rgb       <= rgb_next;
            hsync_out <= hsync_q;
            vsync_out <= vsync_q;
        end
    end

endmodule

// File: tb/tb_grid_renderer.sv
// Scoreboard bench for grid_renderer: a compressed raster scan (hc=0 on
// every line, contiguous hc sweeps on selected lines) with random board,
// cursor, turns, bright and syncs, checked against an arithmetic model.
module tb_grid_renderer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [9:0]   hc = '0;
    logic [9:0]   vc = '0;
    logic         bright = 1'b0;
    logic         hsync_in = 1'b1;
    logic         vsync_in = 1'b1;
    logic [199:0] cell_status_flat = '0;
    logic [4:0]   turns_left = '0;
    logic [3:0]   sprite_row = '0;
    logic [3:0]   sprite_col = '0;
    logic [11:0]  rgb;
    logic         hsync_out;
    logic         vsync_out;

    grid_renderer dut (
        .clk              (clk),
        .reset            (reset),
        .hc               (hc),
        .vc               (vc),
        .bright           (bright),
        .hsync_in         (hsync_in),
        .vsync_in         (vsync_in),
        .cell_status_flat (cell_status_flat),
        .turns_left       (turns_left),
        .sprite_row       (sprite_row),
        .sprite_col       (sprite_col),
        .rgb              (rgb),
        .hsync_out        (hsync_out),
        .vsync_out        (vsync_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        int          h;
        int          v;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t        sb[$];
    int unsigned posedges = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // Reference state: board contents, cursor, turns, and whether the scan
    // has passed the grid origin since the last reset.
    logic [1:0] board[100];
    int         tl = 15;
    int         sr = 0;
    int         sc = 0;
    bit         xok = 0;
    bit         yok = 0;

    function automatic logic [11:0] model(int h, int v, bit br);
        int col, row, px, py;
        if (!br) return 12'h000;
        if (xok && yok && h >= 144 && h < 544 && v >= 35 && v < 435) begin
            col = (h - 144) / 40;
            px  = (h - 144) % 40;
            row = (v - 35) / 40;
            py  = (v - 35) % 40;
            if (row == sr && col == sc && (px < 2 || px >= 38 || py < 2 || py >= 38))
                return 12'hFF0;
            if (px == 0 || py == 0) return 12'hFFF;
            case (board[row * 10 + col])
                2'b00:   return 12'h00F;
                2'b01:   return 12'h888;
                2'b10:   return 12'h000;
                default: return 12'hF00;
            endcase
        end
        if (v >= 450 && v < 460 && h >= 144 && h < 144 + tl * 16) return 12'h0F0;
        return 12'h222;
    endfunction

    task automatic check(input string name, input int h, input int v,
                         input logic [11:0] got, input logic [11:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s hc=%0d vc=%0d got=%h expected=%h", name, h, v, got, want);
        end
    endtask

    task automatic drive(input int h, input int v);
        exp_t e;
        @(negedge clk);
        hc       = 10'(h);
        vc       = 10'(v);
        bright   = ($urandom_range(15) != 0);
        hsync_in = 1'($urandom_range(1));
        vsync_in = 1'($urandom_range(1));
        for (int i = 0; i < 100; i++) cell_status_flat[i*2 +: 2] = board[i];
        turns_left = 5'(tl);
        sprite_row = 4'(sr);
        sprite_col = 4'(sc);
        if (h == 144) xok = 1;
        if (h == 0 && v == 35) yok = 1;
        e.due = posedges + 2;
        e.h   = h;
        e.v   = v;
        e.rgb = model(h, v, bright);
        e.hs  = hsync_in;
        e.vs  = vsync_in;
        sb.push_back(e);
    endtask

    task automatic do_reset(input int h, input int v);
        #2 reset = 1'b1;
        #1;
        check("async_reset_rgb", h, v, rgb, 12'h000);
        check("async_reset_hsync", h, v, {11'd0, hsync_out}, 12'h001);
        check("async_reset_vsync", h, v, {11'd0, vsync_out}, 12'h001);
        sb.delete();
        xok = 0;
        yok = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic bit forced_line(int v);
        return v == 35 || v == 36 || v == 55 || v == 74 || v == 75 || v == 95 ||
               v == 255 || v == 434 || v == 435 || v == 453;
    endfunction

    task automatic run_frame(input int f);
        for (int v = 0; v < 480; v++) begin
            if (v == 0) begin
                if (f == 1) begin
                    for (int i = 0; i < 100; i++) board[i] = 2'b00;
                    sr = 0; sc = 0; tl = 15;
                end else if (f == 2) begin
                    for (int i = 0; i < 100; i++) board[i] = 2'($urandom_range(3));
                    board[16] = 2'b10;
                    board[59] = 2'b11;
                    sr = $urandom_range(9); sc = $urandom_range(9); tl = 0;
                end else begin
                    for (int i = 0; i < 100; i++) board[i] = 2'($urandom_range(3));
                    sr = $urandom_range(11); sc = $urandom_range(11);
                    tl = $urandom_range(15);
                end
            end else if (f == 3 && $urandom_range(31) == 0) begin
                sr = $urandom_range(11); sc = $urandom_range(11);
                tl = $urandom_range(15);
            end
            drive(0, v);
            if (forced_line(v) || $urandom_range(15) == 0) begin
                for (int h = 140; h <= 560; h++) begin
                    drive(h, v);
                    if (f == 2 && v == 100 && h == 300) do_reset(h, v);
                end
            end
        end
    endtask

    // Monitor: compare every output presented against the due scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            posedges++;
            #1;
            if (!reset) begin
                while (sb.size() > 0 && sb[0].due < posedges) begin
                    e = sb.pop_front();
                    check("missed_entry", e.h, e.v, 12'hFFF, 12'h000);
                end
                if (sb.size() > 0 && sb[0].due == posedges) begin
                    e = sb.pop_front();
                    check("rgb", e.h, e.v, rgb, e.rgb);
                    check("hsync_out", e.h, e.v, {11'd0, hsync_out}, {11'd0, e.hs});
                    check("vsync_out", e.h, e.v, {11'd0, vsync_out}, {11'd0, e.vs});
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 100; i++) board[i] = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", 0, 0, rgb, 12'h000);
        check("reset_hsync", 0, 0, {11'd0, hsync_out}, 12'h001);
        check("reset_vsync", 0, 0, {11'd0, vsync_out}, 12'h001);
        @(negedge clk);
        reset = 1'b0;
        for (int f = 1; f <= 3; f++) run_frame(f);
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 0, 0, 12'(sb.size()), 12'h000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
